// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the host-side UART command initiator:
//   - transaction status codes reported on status_o
//   - ASCII constants used by the responder rule
//   - initiator FSM state encoding
//   - expect_resp(): the reply the FPGA responder is supposed to send
//   - sat_inc16(): saturating increment for the 16-bit statistics counters
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  // Transaction status codes
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_MISMATCH = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

  // ASCII constants
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_C = 8'h43;

  // Initiator FSM states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_TX   = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  // The responder answers "B" with "C" and echoes every other byte.
  function automatic logic [7:0] expect_resp(input logic [7:0] cmd);
    return (cmd == CH_B) ? CH_C : cmd;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_resp_timer.sv
// -----------------------------------------------------------------------------
// uart_resp_timer
// Reply-window timer for the UART command initiator. Counts enabled cycles
// after a clear and flags the last cycle of a TIMEOUT_CYC-cycle window. The
// count stops at the terminal value, so expired_o stays high until cleared.
//
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   clear_i    in  synchronous clear to zero (has priority over en_i)
//   en_i       in  count enable
//   expired_o  out high while the count equals TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module uart_resp_timer #(
  parameter int TIMEOUT_CYC = 200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TERM);

endmodule

// File: rtl/uart_cmd_initiator.sv
// -----------------------------------------------------------------------------
// uart_cmd_initiator
// Host-side command initiator for the FPGA UART command/echo responder. Takes
// one command byte from the request port, sends it through uart_tx, waits for
// the reply from uart_rx, checks it against the responder rule ("B" -> "C",
// anything else echoed) and retries up to MAX_RETRY extra times on a wrong or
// missing reply.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid_i/_ready_o  request handshake (ready only in IDLE)
//   req_cmd_i             command byte, captured on accept
//   tx_data_o/tx_start_o  byte and one-cycle start pulse to uart_tx
//   tx_busy_i             uart_tx busy flag
//   rx_data_i/rx_valid_i  byte and one-cycle valid pulse from uart_rx
//   done_o                one-cycle pulse at transaction end
//   status_o              00 OK, 01 MISMATCH, 10 TIMEOUT (held until next done)
//   resp_o                last received byte, 00 if the final attempt timed out
//   attempts_o            attempts used by the last transaction
//   ok_cnt_o/err_cnt_o    saturating transaction counters
// -----------------------------------------------------------------------------
module uart_cmd_initiator
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200_000,
  parameter int MAX_RETRY   = 2,
  parameter int RW          = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  input  logic [7:0]    req_cmd_i,
  output logic          req_ready_o,
  output logic [7:0]    tx_data_o,
  output logic          tx_start_o,
  input  logic          tx_busy_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          done_o,
  output logic [1:0]    status_o,
  output logic [7:0]    resp_o,
  output logic [RW-1:0] attempts_o,
  output logic [15:0]   ok_cnt_o,
  output logic [15:0]   err_cnt_o
);

  localparam logic [RW-1:0] MAX_ATT = RW'(MAX_RETRY + 1);

  state_e        state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    exp_q, exp_d;
  logic [RW-1:0] att_q, att_d;
  logic          busy_seen_q, busy_seen_d;
  logic          rx_got_q, rx_got_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          tmo_q, tmo_d;
  logic [1:0]    status_q, status_d;
  logic [7:0]    resp_q, resp_d;
  logic [RW-1:0] attempts_q, attempts_d;
  logic [15:0]   ok_cnt_q, ok_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic tmr_clear, tmr_en, tmr_expired;
  logic chk_ok;

  uart_resp_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  // A timed-out attempt never counts as a match, whatever rx_byte_q holds.
  assign chk_ok = !tmo_q && (rx_byte_q == exp_q);

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    exp_d       = exp_q;
    att_d       = att_q;
    busy_seen_d = busy_seen_q;
    rx_got_d    = rx_got_q;
    rx_byte_d   = rx_byte_q;
    tmo_d       = tmo_q;
    status_d    = status_q;
    resp_d      = resp_q;
    attempts_d  = attempts_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    tmr_clear   = 1'b0;
    tmr_en      = 1'b0;
    tx_start_o  = 1'b0;
    done_o      = 1'b0;
    req_ready_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          tx_data_d = req_cmd_i;
          exp_d     = expect_resp(req_cmd_i);
          att_d     = '0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        // Fresh per-attempt bookkeeping; tx_data_q is reused on retries.
        tx_start_o  = 1'b1;
        att_d       = att_q + 1'b1;
        busy_seen_d = 1'b0;
        rx_got_d    = 1'b0;
        rx_byte_d   = '0;
        tmo_d       = 1'b0;
        state_d     = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        tmr_clear = 1'b1;
        if (tx_busy_i) begin
          busy_seen_d = 1'b1;
        end
        // A fast responder can answer before our own frame is reported
        // finished; keep only the first byte of the attempt.
        if (rx_valid_i && !rx_got_q) begin
          rx_got_d  = 1'b1;
          rx_byte_d = rx_data_i;
        end
        if (busy_seen_q && !tx_busy_i) begin
          state_d = (rx_got_q || rx_valid_i) ? S_CHECK : S_WAIT_RESP;
        end
      end

      S_WAIT_RESP: begin
        tmr_en = 1'b1;
        // A reply on the final window cycle takes priority over the timeout.
        if (rx_valid_i) begin
          rx_byte_d = rx_data_i;
          state_d   = S_CHECK;
        end else if (tmr_expired) begin
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (!chk_ok && (att_q < MAX_ATT)) begin
          state_d = S_SEND;
        end else begin
          // Results are registered here so they are already valid while
          // done_o is high in the following cycle.
          state_d    = S_DONE;
          attempts_d = att_q;
          resp_d     = tmo_q ? 8'h00 : rx_byte_q;
          if (chk_ok) begin
            status_d = ST_OK;
            ok_cnt_d = sat_inc16(ok_cnt_q);
          end else begin
            status_d  = tmo_q ? ST_TIMEOUT : ST_MISMATCH;
            err_cnt_d = sat_inc16(err_cnt_q);
          end
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tx_data_q   <= '0;
      exp_q       <= '0;
      att_q       <= '0;
      busy_seen_q <= 1'b0;
      rx_got_q    <= 1'b0;
      rx_byte_q   <= '0;
      tmo_q       <= 1'b0;
      status_q    <= ST_OK;
      resp_q      <= '0;
      attempts_q  <= '0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      exp_q       <= exp_d;
      att_q       <= att_d;
      busy_seen_q <= busy_seen_d;
      rx_got_q    <= rx_got_d;
      rx_byte_q   <= rx_byte_d;
      tmo_q       <= tmo_d;
      status_q    <= status_d;
      resp_q      <= resp_d;
      attempts_q  <= attempts_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign status_o   = status_q;
  assign resp_o     = resp_q;
  assign attempts_o = attempts_q;
  assign ok_cnt_o   = ok_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_initiator
// Directed bench for uart_cmd_initiator with a byte-level uart_tx/responder
// model: a table of transactions with per-attempt replies and hand-computed
// results, followed by short sequences for the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_uart_cmd_initiator;

  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_RETRY   = 2;
  localparam int RW          = 2;
  localparam int BUSY_CYC    = 8;
  localparam int GUARD       = TIMEOUT_CYC + 60;

  logic          clk;
  logic          rst_n;
  logic          req_valid_i;
  logic [7:0]    req_cmd_i;
  logic          req_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_start_o;
  logic          tx_busy_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          done_o;
  logic [1:0]    status_o;
  logic [7:0]    resp_o;
  logic [RW-1:0] attempts_o;
  logic [15:0]   ok_cnt_o;
  logic [15:0]   err_cnt_o;

  uart_cmd_initiator #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_RETRY  (MAX_RETRY),
    .RW         (RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_cmd_i  (req_cmd_i),
    .req_ready_o(req_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_start_o (tx_start_o),
    .tx_busy_i  (tx_busy_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .done_o     (done_o),
    .status_o   (status_o),
    .resp_o     (resp_o),
    .attempts_o (attempts_o),
    .ok_cnt_o   (ok_cnt_o),
    .err_cnt_o  (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: command, which attempts get a reply and with which
  // byte, reply delay after the TX frame ends, and the expected outcome.
  typedef struct {
    logic [7:0]       cmd;
    logic [2:0]       rsp_en;
    logic [2:0][7:0]  rsp;
    int               dly;
    logic [1:0]       exp_st;
    logic [7:0]       exp_resp;
    int               exp_att;
  } vec_t;

  int checks;
  int errors;
  int start_cnt;
  int done_cnt;
  int exp_ok;
  int exp_err;
  logic [1:0]    d_status;
  logic [7:0]    d_resp;
  logic [RW-1:0] d_att;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock and sample outputs on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (tx_start_o) start_cnt++;
    if (done_o) begin
      done_cnt++;
      d_status = status_o;
      d_resp   = resp_o;
      d_att    = attempts_o;
    end
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input logic [2:0] en,
                              input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input int dly,
                              input logic [1:0] st, input logic [7:0] resp,
                              input int att);
    vec_t v;
    v.cmd      = cmd;
    v.rsp_en   = en;
    v.rsp[0]   = r0;
    v.rsp[1]   = r1;
    v.rsp[2]   = r2;
    v.dly      = dly;
    v.exp_st   = st;
    v.exp_resp = resp;
    v.exp_att  = att;
    return v;
  endfunction

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done_cnt == 0 && guard < 3 * GUARD) begin
      tick();
      guard++;
    end
  endtask

  task automatic issue(input logic [7:0] cmd, input string nm);
    start_cnt   = 0;
    done_cnt    = 0;
    req_valid_i = 1'b1;
    req_cmd_i   = cmd;
    chk({nm, "_ready"}, 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    chk({nm, "_start_lat"}, 32'(start_cnt), 32'd1);
    chk({nm, "_tx_data"}, 32'(tx_data_o), 32'(cmd));
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int    a;
    int    guard;
    string nm;
    nm = $sformatf("v%0d", idx);
    issue(v.cmd, nm);
    a = 0;
    while (done_cnt == 0 && a < 3) begin
      guard = 0;
      while (start_cnt < a + 1 && done_cnt == 0 && guard < GUARD) begin
        tick();
        guard++;
      end
      if (start_cnt < a + 1) break;
      tx_busy_i = 1'b1;
      repeat (BUSY_CYC) tick();
      tx_busy_i = 1'b0;
      if (v.rsp_en[a]) begin
        repeat (v.dly) tick();
        rx_valid_i = 1'b1;
        rx_data_i  = v.rsp[a];
        tick();
        rx_valid_i = 1'b0;
      end
      a++;
    end
    wait_done();
    repeat (5) tick();
    if (v.exp_st == 2'b00) exp_ok++;
    else exp_err++;
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, "_starts"}, 32'(start_cnt), 32'(v.exp_att));
    chk({nm, "_status"}, 32'(d_status), 32'(v.exp_st));
    chk({nm, "_resp"}, 32'(d_resp), 32'(v.exp_resp));
    chk({nm, "_attempts"}, 32'(d_att), 32'(v.exp_att));
    chk({nm, "_ok_cnt"}, 32'(ok_cnt_o), 32'(exp_ok));
    chk({nm, "_err_cnt"}, 32'(err_cnt_o), 32'(exp_err));
    chk({nm, "_ready_after"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    start_cnt   = 0;
    done_cnt    = 0;
    exp_ok      = 0;
    exp_err     = 0;
    d_status    = '0;
    d_resp      = '0;
    d_att       = '0;
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_cmd_i   = '0;
    tx_busy_i   = 1'b0;
    rx_data_i   = '0;
    rx_valid_i  = 1'b0;

    //            cmd    en      r0     r1     r2    dly st     resp   att
    vecs[0]  = mk(8'h41, 3'b001, 8'h41, 8'h00, 8'h00, 20, 2'b00, 8'h41, 1);
    vecs[1]  = mk(8'h42, 3'b001, 8'h43, 8'h00, 8'h00, 20, 2'b00, 8'h43, 1);
    vecs[2]  = mk(8'h78, 3'b001, 8'h78, 8'h00, 8'h00, 20, 2'b00, 8'h78, 1);
    vecs[3]  = mk(8'h42, 3'b111, 8'h42, 8'h42, 8'h42, 20, 2'b01, 8'h42, 3);
    vecs[4]  = mk(8'h42, 3'b000, 8'h00, 8'h00, 8'h00, 20, 2'b10, 8'h00, 3);
    vecs[5]  = mk(8'h41, 3'b010, 8'h00, 8'h41, 8'h00, 20, 2'b00, 8'h41, 2);
    vecs[6]  = mk(8'h5A, 3'b111, 8'h59, 8'h59, 8'h5A, 20, 2'b00, 8'h5A, 3);
    vecs[7]  = mk(8'h37, 3'b011, 8'h30, 8'h31, 8'h00, 20, 2'b10, 8'h00, 3);
    vecs[8]  = mk(8'h51, 3'b100, 8'h00, 8'h00, 8'h52,  5, 2'b01, 8'h52, 3);
    vecs[9]  = mk(8'h42, 3'b011, 8'h42, 8'h43, 8'h00, 20, 2'b00, 8'h43, 2);
    // Reply lands on the last cycle of the window: accepted.
    vecs[10] = mk(8'h41, 3'b111, 8'h41, 8'h41, 8'h41, 100, 2'b00, 8'h41, 1);
    // Reply one cycle after the window: ignored every time.
    vecs[11] = mk(8'h41, 3'b111, 8'h41, 8'h41, 8'h41, 101, 2'b10, 8'h00, 3);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_tx_start", 32'(tx_start_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_status", 32'(status_o), 32'd0);
    chk("rst_resp", 32'(resp_o), 32'd0);
    chk("rst_attempts", 32'(attempts_o), 32'd0);
    chk("rst_ok_cnt", 32'(ok_cnt_o), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_txn(i, vecs[i]);
    end

    // Reply arrives while the TX frame is still busy; a second byte in the
    // same attempt must be ignored.
    issue(8'h41, "early");
    tx_busy_i = 1'b1;
    repeat (3) tick();
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h41;
    tick();
    rx_data_i  = 8'h5A;
    tick();
    rx_valid_i = 1'b0;
    repeat (2) tick();
    tx_busy_i = 1'b0;
    wait_done();
    repeat (3) tick();
    exp_ok++;
    chk("early_done_cnt", 32'(done_cnt), 32'd1);
    chk("early_starts", 32'(start_cnt), 32'd1);
    chk("early_status", 32'(d_status), 32'd0);
    chk("early_resp", 32'(d_resp), 32'h41);
    chk("early_ok_cnt", 32'(ok_cnt_o), 32'(exp_ok));

    // rx_valid_i -> done_o takes two cycles.
    issue(8'h42, "lat");
    tx_busy_i = 1'b1;
    repeat (BUSY_CYC) tick();
    tx_busy_i = 1'b0;
    repeat (20) tick();
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h43;
    tick();
    rx_valid_i = 1'b0;
    chk("lat_done_c1", 32'(done_o), 32'd0);
    tick();
    chk("lat_done_c2", 32'(done_o), 32'd1);
    chk("lat_status", 32'(status_o), 32'd0);
    chk("lat_resp", 32'(resp_o), 32'h43);
    tick();
    chk("lat_done_c3", 32'(done_o), 32'd0);
    chk("lat_ready", 32'(req_ready_o), 32'd1);
    exp_ok++;

    // Stray bytes while idle do nothing.
    done_cnt  = 0;
    start_cnt = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h41;
    repeat (3) tick();
    rx_valid_i = 1'b0;
    repeat (5) tick();
    chk("stray_done", 32'(done_cnt), 32'd0);
    chk("stray_start", 32'(start_cnt), 32'd0);
    chk("stray_ready", 32'(req_ready_o), 32'd1);
    chk("stray_ok_cnt", 32'(ok_cnt_o), 32'(exp_ok));

    // Reset in the middle of WAIT_RESP abandons the transaction.
    issue(8'h42, "rst");
    tx_busy_i = 1'b1;
    repeat (BUSY_CYC) tick();
    tx_busy_i = 1'b0;
    repeat (10) tick();
    chk("rst_mid_ready_before", 32'(req_ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
    chk("rst_mid_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_mid_status", 32'(status_o), 32'd0);
    chk("rst_mid_resp", 32'(resp_o), 32'd0);
    chk("rst_mid_attempts", 32'(attempts_o), 32'd0);
    chk("rst_mid_ok_cnt", 32'(ok_cnt_o), 32'd0);
    chk("rst_mid_err_cnt", 32'(err_cnt_o), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    done_cnt  = 0;
    start_cnt = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h43;
    tick();
    rx_valid_i = 1'b0;
    repeat (10) tick();
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_no_start", 32'(start_cnt), 32'd0);
    chk("rst_mid_ok_after", 32'(ok_cnt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
